// File: rtl/ctrl_pkg.sv
// Shared constants and types for the Mini-SRC control sequencer: opcodes,
// state encoding, IR field positions and the op classification used by decode.
package ctrl_pkg;

   localparam logic [3:0] MEM_WAIT_MAX = 4'd15;

   localparam int unsigned IR_OP_MSB = 31;
   localparam int unsigned IR_OP_LSB = 27;
   localparam int unsigned IR_RA_MSB = 26;
   localparam int unsigned IR_RA_LSB = 23;
   localparam int unsigned IR_RB_MSB = 22;
   localparam int unsigned IR_RB_LSB = 19;
   localparam int unsigned IR_RC_MSB = 18;
   localparam int unsigned IR_RC_LSB = 15;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10010;
   localparam logic [4:0] OP_NOT  = 5'b10011;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      ST_HALT = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_T3   = 4'd4,
      ST_T4   = 4'd5,
      ST_T5   = 4'd6,
      ST_T6   = 4'd7
   } state_e;

   typedef enum logic [2:0] {
      CLS_THREE   = 3'd0,
      CLS_UNARY   = 3'd1,
      CLS_MULDIV  = 3'd2,
      CLS_NOP     = 3'd3,
      CLS_HALT    = 3'd4,
      CLS_ILLEGAL = 3'd5
   } op_class_e;

   function automatic logic [4:0] ir_op(input logic [31:0] ir);
      return ir[IR_OP_MSB:IR_OP_LSB];
   endfunction

   function automatic logic [3:0] ir_ra(input logic [31:0] ir);
      return ir[IR_RA_MSB:IR_RA_LSB];
   endfunction

   function automatic logic [3:0] ir_rb(input logic [31:0] ir);
      return ir[IR_RB_MSB:IR_RB_LSB];
   endfunction

   function automatic logic [3:0] ir_rc(input logic [31:0] ir);
      return ir[IR_RC_MSB:IR_RC_LSB];
   endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Handshake and strobe bundle between ctrl_sequencer (master) and the
// datapath (slave).
interface ctrl_sequencer_if;

   logic        run;
   logic        stop;
   logic        mem_ready;
   logic [31:0] IR;

   logic        PCout;
   logic        MARin;
   logic        IncPC;
   logic        Zin;
   logic        Zlowout;
   logic        Zhighout;
   logic        PCin;
   logic        Read;
   logic        MDRin;
   logic        MDRout;
   logic        IRin;
   logic        Yin;
   logic        HIin;
   logic        LOin;
   logic        reg_in_en;
   logic        reg_out_en;
   logic [3:0]  reg_in_sel;
   logic [3:0]  reg_out_sel;
   logic [4:0]  opcode;
   logic        halted;
   logic        illegal;
   logic        mem_timeout;

   modport master (
      input  run, stop, mem_ready, IR,
      output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
             MDRout, IRin, Yin, HIin, LOin, reg_in_en, reg_out_en,
             reg_in_sel, reg_out_sel, opcode, halted, illegal, mem_timeout
   );

   modport slave (
      output run, stop, mem_ready, IR,
      input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
             MDRout, IRin, Yin, HIin, LOin, reg_in_en, reg_out_en,
             reg_in_sel, reg_out_sel, opcode, halted, illegal, mem_timeout
   );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier. mul/div count as supported only when
// CTRL_MULDIV_EN is defined; otherwise they fall into the illegal class.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [4:0] op_i,
   output op_class_e  class_o
);

   // Map each opcode onto the execute path it needs.
   always_comb begin
      class_o = CLS_ILLEGAL;
      case (op_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  class_o = CLS_THREE;
         OP_NEG, OP_NOT:                   class_o = CLS_UNARY;
`ifdef CTRL_MULDIV_EN
         OP_MUL, OP_DIV:                   class_o = CLS_MULDIV;
`endif
         OP_NOP:                           class_o = CLS_NOP;
         OP_HALT:                          class_o = CLS_HALT;
         default:                          class_o = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/ctrl_sequencer.sv
// Moore control sequencer for the Mini-SRC datapath: fetch (T0-T2) and
// register-register execute (T3-T6). Define CTRL_MULDIV_EN for the HI/LO path.
module ctrl_sequencer
   import ctrl_pkg::*;
(
   input  logic             Clock,
   input  logic             clear,
   ctrl_sequencer_if.master ctl
);

   state_e     state_q, state_d;
   logic [3:0] wait_q, wait_d;
   logic       illegal_q, illegal_d;
   logic       timeout_q, timeout_d;

   logic [4:0] op_s;
   logic [3:0] ra_s, rb_s, rc_s;
   op_class_e  class_s;
   state_e     boundary_s;
   logic       unused_ir_s;

   logic       pcout_s, marin_s, incpc_s, zin_s, zlowout_s, pcin_s;
   logic       read_s, mdrin_s, mdrout_s, irin_s, yin_s;
   logic       reg_in_en_s, reg_out_en_s, halted_s;
   logic [3:0] reg_in_sel_s, reg_out_sel_s;
   logic [4:0] opcode_s;
`ifdef CTRL_MULDIV_EN
   logic       zhighout_s, hiin_s, loin_s;
`endif

   assign op_s        = ir_op(ctl.IR);
   assign ra_s        = ir_ra(ctl.IR);
   assign rb_s        = ir_rb(ctl.IR);
   assign rc_s        = ir_rc(ctl.IR);
   assign unused_ir_s = ^ctl.IR[14:0];
   // stop is only honoured at an instruction boundary
   assign boundary_s  = ctl.stop ? ST_HALT : ST_T0;

   ctrl_decode u_decode (
      .op_i    (op_s),
      .class_o (class_s)
   );

   // State, T1 wait counter and sticky fault flags.
   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state_q   <= ST_HALT;
         wait_q    <= 4'd0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state logic; flags are only set on the way into HALT.
   always_comb begin
      state_d   = state_q;
      wait_d    = 4'd0;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      case (state_q)
         ST_HALT: begin
            if (ctl.run) begin
               state_d   = ST_T0;
               illegal_d = 1'b0;
               timeout_d = 1'b0;
            end else begin
               state_d   = ST_HALT;
            end
         end
         ST_T0: state_d = ST_T1;
         ST_T1: begin
            if (ctl.mem_ready) begin
               state_d = ST_T2;
            end else if (wait_q == MEM_WAIT_MAX) begin
               state_d   = ST_HALT;
               timeout_d = 1'b1;
            end else begin
               state_d = ST_T1;
               wait_d  = wait_q + 4'd1;
            end
         end
         ST_T2: begin
            case (class_s)
               CLS_NOP:                          state_d = boundary_s;
               CLS_HALT:                         state_d = ST_HALT;
               CLS_THREE, CLS_UNARY, CLS_MULDIV: state_d = ST_T3;
               default: begin
                  state_d   = ST_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         ST_T3: state_d = ST_T4;
         ST_T4: state_d = ST_T5;
         ST_T5: begin
`ifdef CTRL_MULDIV_EN
            if (class_s == CLS_MULDIV) begin
               state_d = ST_T6;
            end else begin
               state_d = boundary_s;
            end
`else
            state_d = boundary_s;
`endif
         end
`ifdef CTRL_MULDIV_EN
         ST_T6: state_d = boundary_s;
`endif
         default: state_d = ST_HALT;
      endcase
   end

   // Moore strobe decode from the state register and the current IR.
   always_comb begin
      pcout_s       = 1'b0;
      marin_s       = 1'b0;
      incpc_s       = 1'b0;
      zin_s         = 1'b0;
      zlowout_s     = 1'b0;
      pcin_s        = 1'b0;
      read_s        = 1'b0;
      mdrin_s       = 1'b0;
      mdrout_s      = 1'b0;
      irin_s        = 1'b0;
      yin_s         = 1'b0;
      reg_in_en_s   = 1'b0;
      reg_out_en_s  = 1'b0;
      reg_in_sel_s  = 4'd0;
      reg_out_sel_s = 4'd0;
      opcode_s      = 5'd0;
      halted_s      = 1'b0;
`ifdef CTRL_MULDIV_EN
      zhighout_s    = 1'b0;
      hiin_s        = 1'b0;
      loin_s        = 1'b0;
`endif
      case (state_q)
         ST_HALT: halted_s = 1'b1;
         ST_T0: begin
            pcout_s = 1'b1;
            marin_s = 1'b1;
            incpc_s = 1'b1;
            zin_s   = 1'b1;
         end
         ST_T1: begin
            zlowout_s = 1'b1;
            pcin_s    = 1'b1;
            read_s    = 1'b1;
            mdrin_s   = 1'b1;
         end
         ST_T2: begin
            mdrout_s = 1'b1;
            irin_s   = 1'b1;
         end
         ST_T3: begin
            reg_out_en_s  = 1'b1;
            reg_out_sel_s = rb_s;
            yin_s         = 1'b1;
         end
         ST_T4: begin
            reg_out_en_s  = 1'b1;
            reg_out_sel_s = (class_s == CLS_UNARY) ? rb_s : rc_s;
            zin_s         = 1'b1;
            opcode_s      = op_s;
         end
         ST_T5: begin
            zlowout_s = 1'b1;
`ifdef CTRL_MULDIV_EN
            if (class_s == CLS_MULDIV) begin
               loin_s = 1'b1;
            end else begin
               reg_in_en_s  = 1'b1;
               reg_in_sel_s = ra_s;
            end
`else
            reg_in_en_s  = 1'b1;
            reg_in_sel_s = ra_s;
`endif
         end
`ifdef CTRL_MULDIV_EN
         ST_T6: begin
            zhighout_s = 1'b1;
            hiin_s     = 1'b1;
         end
`endif
         default: halted_s = 1'b0;
      endcase
   end

   assign ctl.PCout       = pcout_s;
   assign ctl.MARin       = marin_s;
   assign ctl.IncPC       = incpc_s;
   assign ctl.Zin         = zin_s;
   assign ctl.Zlowout     = zlowout_s;
   assign ctl.PCin        = pcin_s;
   assign ctl.Read        = read_s;
   assign ctl.MDRin       = mdrin_s;
   assign ctl.MDRout      = mdrout_s;
   assign ctl.IRin        = irin_s;
   assign ctl.Yin         = yin_s;
   assign ctl.reg_in_en   = reg_in_en_s;
   assign ctl.reg_out_en  = reg_out_en_s;
   assign ctl.reg_in_sel  = reg_in_sel_s;
   assign ctl.reg_out_sel = reg_out_sel_s;
   assign ctl.opcode      = opcode_s;
   assign ctl.halted      = halted_s;
   assign ctl.illegal     = illegal_q;
   assign ctl.mem_timeout = timeout_q;
`ifdef CTRL_MULDIV_EN
   assign ctl.Zhighout    = zhighout_s;
   assign ctl.HIin        = hiin_s;
   assign ctl.LOin        = loin_s;
`else
   assign ctl.Zhighout    = 1'b0;
   assign ctl.HIin        = 1'b0;
   assign ctl.LOin        = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a small register/ALU datapath model driven by the
// strobes, a table of instructions and a per-cycle expected-strobe queue.
module tb_ctrl_sequencer;

   logic Clock = 1'b0;
   logic clear;
   always #5 Clock = ~Clock;

   ctrl_sequencer_if bus_if ();

   ctrl_sequencer dut (
      .Clock (Clock),
      .clear (clear),
      .ctl   (bus_if.master)
   );

   typedef enum int {E_HALT, E_T0, E_T1, E_T2, E_T3, E_T4, E_T5A, E_T5M, E_T6} est_e;
   typedef enum int {K_ALU, K_NOP, K_HLT, K_MULDIV, K_ILL} kind_e;

   typedef struct packed {
      logic       PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read;
      logic       MDRin, MDRout, IRin, Yin, HIin, LOin, reg_in_en, reg_out_en;
      logic [3:0] reg_in_sel;
      logic [3:0] reg_out_sel;
      logic [4:0] opcode;
      logic       halted;
   } snap_t;

   typedef struct {
      string       name;
      logic [31:0] ir;
      logic [31:0] b_val;
      logic [31:0] c_val;
      kind_e       kind;
      logic [31:0] exp_res;
      logic [31:0] exp_hi;
   } vec_t;

   int          total = 0;
   int          bad   = 0;
   snap_t       exp_q[$];
   vec_t        vecs[$];
   logic [31:0] exp_pc = 32'd0;

   // datapath model
   logic [31:0] r [16];
   logic [31:0] y  = 32'd0;
   logic [31:0] pc = 32'd0;
   logic [31:0] lo = 32'd0;
   logic [31:0] hi = 32'd0;
   logic [63:0] z  = 64'd0;
   logic [31:0] dbus;
   logic        pl_we  = 1'b0;
   logic [3:0]  pl_idx = 4'd0;
   logic [31:0] pl_val = 32'd0;

   function automatic logic [63:0] alu(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
      case (opc)
         5'b00011: return {32'd0, a + b};
         5'b00100: return {32'd0, a - b};
         5'b00101: return {32'd0, a & b};
         5'b00110: return {32'd0, a | b};
         5'b01011: return {32'd0, a << b[4:0]};
         5'b01111: return {32'd0, a} * {32'd0, b};
         5'b10000: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
         5'b10010: return {32'd0, 32'd0 - b};
         5'b10011: return {32'd0, ~b};
         default:  return 64'd0;
      endcase
   endfunction

   always_comb begin
      dbus = 32'd0;
      if (bus_if.PCout)           dbus = pc;
      else if (bus_if.Zlowout)    dbus = z[31:0];
      else if (bus_if.Zhighout)   dbus = z[63:32];
      else if (bus_if.reg_out_en) dbus = r[bus_if.reg_out_sel];
   end

   always @(posedge Clock) begin
      if (pl_we)            r[pl_idx] <= pl_val;
      if (bus_if.reg_in_en) r[bus_if.reg_in_sel] <= dbus;
      if (bus_if.Yin)       y <= dbus;
      if (bus_if.Zin)       z <= bus_if.IncPC ? {32'd0, pc + 32'd1} : alu(bus_if.opcode, y, dbus);
      if (bus_if.PCin)      pc <= dbus;
      if (bus_if.LOin)      lo <= dbus;
      if (bus_if.HIin)      hi <= dbus;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic snap_t get_snap();
      snap_t s;
      s.PCout = bus_if.PCout;     s.MARin = bus_if.MARin;     s.IncPC = bus_if.IncPC;
      s.Zin = bus_if.Zin;         s.Zlowout = bus_if.Zlowout; s.Zhighout = bus_if.Zhighout;
      s.PCin = bus_if.PCin;       s.Read = bus_if.Read;       s.MDRin = bus_if.MDRin;
      s.MDRout = bus_if.MDRout;   s.IRin = bus_if.IRin;       s.Yin = bus_if.Yin;
      s.HIin = bus_if.HIin;       s.LOin = bus_if.LOin;       s.reg_in_en = bus_if.reg_in_en;
      s.reg_out_en = bus_if.reg_out_en;
      s.reg_in_sel = bus_if.reg_in_sel;
      s.reg_out_sel = bus_if.reg_out_sel;
      s.opcode = bus_if.opcode;
      s.halted = bus_if.halted;
      return s;
   endfunction

   function automatic snap_t exp_snap(input est_e st, input logic [31:0] ir);
      snap_t s;
      s = '0;
      case (st)
         E_HALT: s.halted = 1'b1;
         E_T0:   begin s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1; s.Zin = 1'b1; end
         E_T1:   begin s.Zlowout = 1'b1; s.PCin = 1'b1; s.Read = 1'b1; s.MDRin = 1'b1; end
         E_T2:   begin s.MDRout = 1'b1; s.IRin = 1'b1; end
         E_T3:   begin s.reg_out_en = 1'b1; s.reg_out_sel = ir[22:19]; s.Yin = 1'b1; end
         E_T4: begin
            s.reg_out_en  = 1'b1;
            s.reg_out_sel = (ir[31:27] == 5'b10010 || ir[31:27] == 5'b10011) ? ir[22:19] : ir[18:15];
            s.Zin         = 1'b1;
            s.opcode      = ir[31:27];
         end
         E_T5A:  begin s.Zlowout = 1'b1; s.reg_in_en = 1'b1; s.reg_in_sel = ir[26:23]; end
         E_T5M:  begin s.Zlowout = 1'b1; s.LOin = 1'b1; end
         E_T6:   begin s.Zhighout = 1'b1; s.HIin = 1'b1; end
         default: s = '0;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   // Pushes the expected per-cycle strobes of one instruction; returns its length.
   function automatic int push_instr(input kind_e kind, input logic [31:0] ir, input int waits);
      int n;
      n = 1;
      exp_q.push_back(exp_snap(E_T0, ir));
      for (int i = 0; i <= waits && i < 16; i++) begin
         exp_q.push_back(exp_snap(E_T1, ir));
         n++;
      end
      if (waits > 15) return n;
      exp_q.push_back(exp_snap(E_T2, ir));
      n++;
      if (kind == K_ALU || kind == K_MULDIV) begin
         exp_q.push_back(exp_snap(E_T3, ir));
         exp_q.push_back(exp_snap(E_T4, ir));
         n += 2;
         if (kind == K_ALU) begin
            exp_q.push_back(exp_snap(E_T5A, ir));
            n++;
         end else begin
            exp_q.push_back(exp_snap(E_T5M, ir));
            exp_q.push_back(exp_snap(E_T6, ir));
            n += 2;
         end
      end
      return n;
   endfunction

   task automatic preload(input logic [3:0] idx, input logic [31:0] val);
      @(negedge Clock);
      pl_we = 1'b1; pl_idx = idx; pl_val = val;
      @(negedge Clock);
      pl_we = 1'b0;
   endtask

   // Runs reps back-to-back copies of ir from HALT back to HALT, checking every cycle.
   task automatic run_instr(input string nm, input logic [31:0] ir, input kind_e kind,
                            input int waits, input int reps);
      int len;
      int e;
      len = 0;
      for (int k = 0; k < reps; k++) len = push_instr(kind, ir, (k == 0) ? waits : 0);
      exp_q.push_back(exp_snap(E_HALT, ir));
      @(negedge Clock);
      bus_if.IR = ir; bus_if.run = 1'b1; bus_if.stop = (reps == 1); bus_if.mem_ready = 1'b1;
      e = 0;
      while (exp_q.size() > 0) begin
         @(posedge Clock);
         #1;
         e++;
         check($sformatf("%s strobes c%0d", nm, e), 32'(get_snap()), 32'(exp_q.pop_front()));
         if (e == 1) begin
            check({nm, " illegal@T0"}, 32'(bus_if.illegal), 32'd0);
            check({nm, " timeout@T0"}, 32'(bus_if.mem_timeout), 32'd0);
         end
         @(negedge Clock);
         bus_if.run       = 1'b0;
         bus_if.stop      = (reps == 1) || (e > (reps - 1) * len);
         bus_if.mem_ready = !(e >= 2 && e < 2 + waits);
      end
      exp_pc += 32'(reps);
      check({nm, " pc"}, pc, exp_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      clear = 1'b0;
      bus_if.run = 1'b0; bus_if.stop = 1'b0; bus_if.mem_ready = 1'b1; bus_if.IR = 32'd0;

      #12;
      check("reset strobes", 32'(get_snap()), 32'(exp_snap(E_HALT, 32'd0)));
      check("reset illegal", 32'(bus_if.illegal), 32'd0);
      check("reset timeout", 32'(bus_if.mem_timeout), 32'd0);
      @(negedge Clock);
      clear = 1'b1;

      vecs.push_back('{"add",   32'h18918000, 32'd8, 32'd2, K_ALU, 32'd10, 32'd0});
      vecs.push_back('{"sub",   32'h20918000, 32'd8, 32'd2, K_ALU, 32'd6, 32'd0});
      vecs.push_back('{"and",   mk_ir(5'b00101, 4'd4, 4'd5, 4'd6), 32'hC, 32'hA, K_ALU, 32'h8, 32'd0});
      vecs.push_back('{"or",    mk_ir(5'b00110, 4'd4, 4'd5, 4'd6), 32'hC, 32'hA, K_ALU, 32'hE, 32'd0});
      vecs.push_back('{"shl",   mk_ir(5'b01011, 4'd9, 4'd5, 4'd6), 32'd3, 32'd4, K_ALU, 32'h30, 32'd0});
      vecs.push_back('{"neg",   mk_ir(5'b10010, 4'd7, 4'd8, 4'd0), 32'd5, 32'd0, K_ALU, 32'hFFFFFFFB, 32'd0});
      vecs.push_back('{"not",   mk_ir(5'b10011, 4'd9, 4'd10, 4'd0), 32'h0F0F0000, 32'd0, K_ALU, 32'hF0F0FFFF, 32'd0});
      vecs.push_back('{"nop",   mk_ir(5'b11010, 4'd0, 4'd1, 4'd2), 32'd0, 32'd0, K_NOP, 32'd0, 32'd0});
      vecs.push_back('{"ill31", mk_ir(5'b11111, 4'd0, 4'd1, 4'd2), 32'd0, 32'd0, K_ILL, 32'd0, 32'd0});
      vecs.push_back('{"halt",  mk_ir(5'b11011, 4'd0, 4'd1, 4'd2), 32'd0, 32'd0, K_HLT, 32'd0, 32'd0});
      vecs.push_back('{"ill12", mk_ir(5'b01100, 4'd0, 4'd1, 4'd2), 32'd0, 32'd0, K_ILL, 32'd0, 32'd0});
      vecs.push_back('{"ill17", mk_ir(5'b10001, 4'd0, 4'd1, 4'd2), 32'd0, 32'd0, K_ILL, 32'd0, 32'd0});
`ifdef CTRL_MULDIV_EN
      vecs.push_back('{"mul",   mk_ir(5'b01111, 4'd0, 4'd2, 4'd3), 32'd8, 32'd2, K_MULDIV, 32'd16, 32'd0});
      vecs.push_back('{"div",   mk_ir(5'b10000, 4'd0, 4'd2, 4'd3), 32'd9, 32'd2, K_MULDIV, 32'd4, 32'd1});
`else
      vecs.push_back('{"mul",   mk_ir(5'b01111, 4'd0, 4'd2, 4'd3), 32'd8, 32'd2, K_ILL, 32'd0, 32'd0});
      vecs.push_back('{"div",   mk_ir(5'b10000, 4'd0, 4'd2, 4'd3), 32'd9, 32'd2, K_ILL, 32'd0, 32'd0});
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         preload(v.ir[22:19], v.b_val);
         preload(v.ir[18:15], v.c_val);
         run_instr(v.name, v.ir, v.kind, 0, 1);
         case (v.kind)
            K_ALU:    check({v.name, " result"}, r[v.ir[26:23]], v.exp_res);
            K_MULDIV: begin
               check({v.name, " LO"}, lo, v.exp_res);
               check({v.name, " HI"}, hi, v.exp_hi);
            end
            default:  check({v.name, " illegal"}, 32'(bus_if.illegal), (v.kind == K_ILL) ? 32'd1 : 32'd0);
         endcase
      end

      // back-to-back nops with stop low, then stop at the second boundary
      run_instr("nop x2", mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), K_NOP, 0, 2);
      run_instr("add wait3", 32'h18918000, K_ALU, 3, 1);
      run_instr("add wait15", 32'h18918000, K_ALU, 15, 1);
      run_instr("add wait16", 32'h18918000, K_ALU, 16, 1);
      check("timeout flag", 32'(bus_if.mem_timeout), 32'd1);
      check("timeout halted", 32'(bus_if.halted), 32'd1);
      run_instr("nop after timeout", mk_ir(5'b11010, 4'd0, 4'd0, 4'd0), K_NOP, 0, 1);

      // asynchronous clear while in T4
      @(negedge Clock);
      bus_if.IR = 32'h18918000; bus_if.run = 1'b1; bus_if.stop = 1'b1; bus_if.mem_ready = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      bus_if.run = 1'b0;
      repeat (4) @(posedge Clock);
      #2;
      check("pre-clear T4", 32'(get_snap()), 32'(exp_snap(E_T4, 32'h18918000)));
      clear = 1'b0;
      #1;
      check("clear strobes", 32'(get_snap()), 32'(exp_snap(E_HALT, 32'd0)));
      check("clear illegal", 32'(bus_if.illegal), 32'd0);
      check("clear timeout", 32'(bus_if.mem_timeout), 32'd0);
      exp_pc += 32'd1;
      @(negedge Clock);
      clear = 1'b1;
      run_instr("add after clear", 32'h18918000, K_ALU, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Sequences the Mini-SRC style datapath (register file, Y/Z, HI/LO, PC, IR, MAR/MDR, ALU) through instruction fetch and register-register execute. It replaces bench-driven T0–T6 strobes with a clocked Moore state machine. It reads IR[31:0] back from the datapath and emits the control strobes that `datapath` already accepts. It sits beside `datapath` at the CPU top level.

## Interface
- MEM_WAIT_MAX, 15: upper bound of the T1 memory-wait counter; the counter is 4 bits wide.
- Clock  in  1  system clock; all state changes occur on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- run  in  1  level; when high in HALT, starts fetching on the next edge.
- stop  in  1  level; request to halt at the next instruction boundary.
- mem_ready  in  1  memory has data on Mdatain; sampled only in T1.
- IR  in  32  instruction register contents from the datapath.
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- reg_in_en, reg_out_en  out  1 each  enable for the general-register input and output.
- reg_in_sel, reg_out_sel  out  4 each  register index, decoded one-hot into R0in..R15in and R0out..R15out.
- opcode  out  5  ALU operation select.
- halted  out  1  high in the HALT state.
- illegal  out  1  sticky flag for an unsupported opcode.
- mem_timeout  out  1  sticky flag for a T1 timeout.

## Operation
- IR fields: op = IR[31:27], ra = IR[26:23], rb = IR[22:19], rc = IR[18:15].
- States: HALT, T0, T1, T2, T3, T4, T5, T6. Outputs are a Moore decode of the state register plus IR.
- HALT: all strobes are 0 and halted = 1. Goes to T0 when run = 1. Entering T0 clears illegal and mem_timeout.
- T0: PCout, MARin, IncPC, Zin → T1.
- T1: Zlowout, PCin, Read, MDRin.
  - All four strobes are held while mem_ready = 0.
  - Goes to T2 when mem_ready = 1.
  - If MEM_WAIT_MAX cycles pass without mem_ready: mem_timeout is set and the state goes to HALT.
  - Re-asserting PCin while waiting is harmless because Z is unchanged.
- T2: MDRout, IRin. Next state is chosen by op:
  - 11010 (nop) → T0.
  - 11011 (halt) → HALT.
  - Supported ALU op → T3.
  - Anything else → HALT, with illegal set.
- T3: reg_out_en with reg_out_sel = rb, plus Yin.
- T4: reg_out_en with reg_out_sel = rc, plus Zin. For unary ops 10010 (neg) and 10011 (not), reg_out_sel = rb instead.
- During T4 only, opcode = op; in every other state opcode = 0.
- Three-operand ALU ops 00011–01011 (add, sub, and, or, ror, rol, shr, shra, shl) and the unary ops:
  - T5: Zlowout, reg_in_en, reg_in_sel = ra → T0.
- mul 01111 and div 10000 (see Configuration):
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin → T0.
- stop: if stop = 1 on the edge leaving the last execute state (or T2 for nop), the next state is HALT instead of T0. stop is ignored mid-instruction.
- When reg_*_en = 0, the corresponding reg_*_sel = 0.

## Timing
- Every state lasts exactly one cycle, except T1, which lasts 1 + wait cycles.
- Instruction latency, measured from entry to T0 until return to T0:
  - nop: 3 cycles.
  - ALU op: 6 cycles.
  - mul/div: 7 cycles.
  - All of these assume zero memory wait.
- Strobes come from registered state only, so they are stable for the whole cycle. The datapath captures them on the next rising edge.
- Reset (clear = 0), including mid-instruction:
  - State goes to HALT immediately.
  - Every strobe is 0, opcode = 0, halted = 1.
  - illegal = 0, mem_timeout = 0, wait counter = 0.
- If run and stop are both high in HALT, run wins: one instruction executes, then the block halts.

## Configuration
- CTRL_MULDIV_EN defined: mul and div take the T5/T6 HI/LO path.
- CTRL_MULDIV_EN undefined:
  - 01111 and 10000 are illegal (T2 → HALT, illegal set).
  - T6 is not synthesized.
  - HIin, LOin and Zhighout are tied to 0.

## Structure
- Package ctrl_pkg holds:
  - the opcode constants (OP_ADD = 5'b00011, OP_SUB = 5'b00100, etc.);
  - the state encoding, as a 4-bit enum;
  - the IR field bit positions.
- One sub-module, ctrl_decode: a purely combinational classifier of op into three-operand, unary, muldiv, nop, halt or illegal. It is used in the T2 branch and in the T4/T5 decode.

## Test plan
- add R1,R2,R3: IR = 0x18918000, mem_ready tied high, R2 = 8, R3 = 2 → T0..T5 in 6 cycles. In T4, opcode = 00011 and reg_out_sel = 3. In T5, reg_in_sel = 1. R1 = 10.
- sub R1,R2,R3: IR = 0x20918000 → opcode = 00100 in T4 only. R1 = 6.
- mem_ready held low for 3 cycles in T1 → Read and MDRin stay high for 4 cycles, then T2. Held low for 16 cycles → mem_timeout = 1 and halted = 1.
- IR op = 11111 → T2 → HALT with illegal = 1. A following run pulse clears illegal at T0.
- clear pulsed low during T4 → all strobes drop to 0 asynchronously and halted = 1. After clear is released and run = 1, fetch restarts at T0.
- mul R2,R3 with 8 and 2 and CTRL_MULDIV_EN defined → LO = 16, HI = 0 after T6. With the macro undefined → illegal = 1.
